// File: rtl/dvp_rgb565_capture_if.sv
// Camera-side DVP bus plus the packed RGB565 pixel stream, bundled for the capture block.
// Latency: none (wires only).
// Backpressure: none; the pixel stream is push-only.
interface dvp_rgb565_capture_if;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;

    // Camera model / stream consumer side
    modport master (
        output vsync, href, din,
        input  dout, dout_vld, dout_sop, dout_eop
    );

    // Capture block side
    modport slave (
        input  vsync, href, din,
        output dout, dout_vld, dout_sop, dout_eop
    );
endinterface

// File: rtl/dvp_rgb565_capture.sv
// Captures an 8-bit DVP bus and packs byte pairs into framed RGB565 pixels after settling frames.
// Latency: pixel valid 1 clk after the cycle that samples its second byte.
// Backpressure: none; every dout_vld is assumed accepted downstream.
module dvp_rgb565_capture #(
    parameter int H_PIX       = 640,
    parameter int V_LINES     = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_capture,
    dvp_rgb565_capture_if.slave   bus,
    output logic                  frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

    localparam int               SK_W      = $clog2(SKIP_FRAMES + 2);
    localparam logic [SK_W-1:0]  SKIP_LAST = SK_W'(SKIP_FRAMES);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_PIX - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_LINES - 1);

    state_t           state_q, state_d;
    logic [SK_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic             vsync_dly_q, vsync_dly_d;
    logic             href_dly_q, href_dly_d;
    logic             byte_flag_q, byte_flag_d;
    logic [7:0]       hi_q, hi_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [15:0]      dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             err_q, err_d;

    logic fb;
    logic line_fall;
    logic last_col;
    logic last_row;

    assign fb        = bus.vsync & ~vsync_dly_q;
    assign line_fall = href_dly_q & ~bus.href;
    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);

    // State, counters, pairing and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            skip_cnt_q  <= '0;
            vsync_dly_q <= 1'b0;
            href_dly_q  <= 1'b0;
            byte_flag_q <= 1'b0;
            hi_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            vsync_dly_q <= vsync_dly_d;
            href_dly_q  <= href_dly_d;
            byte_flag_q <= byte_flag_d;
            hi_q        <= hi_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    // Frame sequencing, byte pairing, pixel positioning and error detection
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        vsync_dly_d = bus.vsync;
        href_dly_d  = bus.href;
        byte_flag_d = 1'b0;
        hi_d        = hi_q;
        col_d       = col_q;
        row_d       = row_q;
        dout_d      = dout_q;
        vld_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (en_capture) begin
                    state_d    = S_SKIP;
                    skip_cnt_d = '0;
                end
            end
            S_SKIP: begin
                col_d = '0;
                row_d = '0;
                if (fb) begin
                    if (!en_capture)
                        state_d = S_IDLE;
                    else if (skip_cnt_q == SKIP_LAST)
                        state_d = S_CAPTURE;
                    else
                        skip_cnt_d = skip_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (fb) begin
                    // Any boundary seen here arrives before the last pixel: truncated frame.
                    // It also pre-empts a pixel completing in the same cycle.
                    err_d   = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = en_capture ? S_CAPTURE : S_IDLE;
                end else if (bus.href) begin
                    byte_flag_d = ~byte_flag_q;
                    if (!byte_flag_q) begin
                        hi_d = bus.din;
                    end else begin
                        dout_d = {hi_q, bus.din};
                        vld_d  = 1'b1;
                        sop_d  = (col_q == '0) && (row_q == '0);
                        eop_d  = last_col && last_row;
                        if (last_col && last_row) begin
                            state_d = S_DONE;
                            col_d   = '0;
                            row_d   = '0;
                        end else if (last_col) begin
                            // Excess pixels simply spill into the next row
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else if (line_fall && ((col_q != '0) || byte_flag_q)) begin
                    // Short line: drop any dangling byte and move to the next row
                    err_d = 1'b1;
                    col_d = '0;
                    if (last_row) begin
                        state_d = S_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                col_d = '0;
                row_d = '0;
                if (fb)
                    state_d = en_capture ? S_CAPTURE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.dout_sop = sop_q;
    assign bus.dout_eop = eop_q;
    assign frame_err    = err_q;
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture with a 4x2 frame and one settling frame.
// Latency: checks pixel strobe 1 clk after the second byte is sampled.
// Backpressure: none; every pixel strobe is logged.
module tb_dvp_rgb565_capture;
    logic clk;
    logic rst_n;
    logic en_capture;
    logic frame_err;

    dvp_rgb565_capture_if bus_if ();

    dvp_rgb565_capture #(
        .H_PIX(4), .V_LINES(2), .SKIP_FRAMES(1), .COL_W(3), .ROW_W(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_capture(en_capture),
        .bus       (bus_if.slave),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic [17:0] pq[$];   // {dout, sop, eop} of every emitted pixel

    // Log pixels and error pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus_if.dout_vld) pq.push_back({bus_if.dout, bus_if.dout_sop, bus_if.dout_eop});
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.href = 1'b1;
        bus_if.din  = b;
        cyc();
    endtask

    function automatic logic [15:0] px(input logic [7:0] base, input int idx);
        return {base + 8'(idx), 8'hC0 + 8'(idx)};
    endfunction

    task automatic send_line(input logic [7:0] base, input int first, input int n, input bit extra);
        for (int j = 0; j < n; j++) begin
            send_byte(base + 8'(first + j));
            send_byte(8'hC0 + 8'(first + j));
        end
        if (extra) send_byte(8'hEE);
        bus_if.href = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic send_frame(input logic [7:0] base);
        send_line(base, 0, 4, 1'b0);
        send_line(base, 4, 4, 1'b0);
    endtask

    task automatic vs_pulse();
        bus_if.href  = 1'b0;
        bus_if.vsync = 1'b1;
        repeat (3) cyc();
        bus_if.vsync = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic chk_full(input string tag, input logic [7:0] base);
        int ns, ne;
        ns = 0;
        ne = 0;
        chk({tag, "_count"}, pq.size(), 8);
        for (int i = 0; i < pq.size(); i++) begin
            ns += int'(pq[i][1]);
            ne += int'(pq[i][0]);
        end
        chk({tag, "_nsop"}, ns, 1);
        chk({tag, "_neop"}, ne, 1);
        chk({tag, "_first"}, pq[0], {px(base, 0), 2'b10});
        chk({tag, "_last"}, pq[7], {px(base, 7), 2'b01});
    endtask

    initial begin
        int eb;
        int ne;
        rst_n        = 1'b0;
        en_capture   = 1'b0;
        bus_if.vsync = 1'b0;
        bus_if.href  = 1'b0;
        bus_if.din   = 8'h00;
        repeat (3) cyc();
        chk("rst_vld", bus_if.dout_vld, 0);
        chk("rst_dout", bus_if.dout, 0);
        chk("rst_sop_eop", {bus_if.dout_sop, bus_if.dout_eop}, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        cyc();

        // Skip: first frame after enable is discarded
        en_capture = 1'b1;
        cyc();
        vs_pulse();
        send_frame(8'h10);
        chk("skip_no_pixels", pq.size(), 0);

        // Packing and latency in the first captured frame
        vs_pulse();
        send_byte(8'hF8);
        chk("pack_first_byte_novld", bus_if.dout_vld, 0);
        send_byte(8'h00);
        chk("pack_p0_vld", bus_if.dout_vld, 1);
        chk("pack_p0_dout", bus_if.dout, 16'hF800);
        chk("pack_p0_sop", bus_if.dout_sop, 1);
        send_byte(8'h07);
        chk("pack_hold_novld", bus_if.dout_vld, 0);
        chk("pack_hold_dout", bus_if.dout, 16'hF800);
        send_byte(8'hE0);
        chk("pack_p1_dout", {bus_if.dout_vld, bus_if.dout}, {1'b1, 16'h07E0});
        chk("pack_p1_sop", bus_if.dout_sop, 0);
        send_line(8'h20, 2, 2, 1'b0);
        send_byte(8'h24);
        send_byte(8'hC4);
        send_byte(8'h25);
        send_byte(8'hC5);
        send_byte(8'h26);
        send_byte(8'hC6);
        send_byte(8'h27);
        send_byte(8'hC7);
        chk("frame_eop_direct", {bus_if.dout_vld, bus_if.dout_eop}, 2'b11);
        bus_if.href = 1'b0;
        cyc();
        cyc();
        chk("frame_count", pq.size(), 8);
        chk("frame_p0", pq[0], {16'hF800, 2'b10});
        chk("frame_p1", pq[1], {16'h07E0, 2'b00});
        chk("frame_p4", pq[4], {16'h24C4, 2'b00});
        chk("frame_p7", pq[7], {16'h27C7, 2'b01});
        chk("frame_no_err", err_cnt, 0);

        // DONE ignores further data
        send_line(8'h30, 0, 4, 1'b0);
        chk("done_ignores", pq.size(), 8);

        // Short line: 3 pixels + dangling byte
        vs_pulse();
        chk("done_fb_noerr", err_cnt, 0);
        pq.delete();
        send_line(8'h40, 0, 3, 1'b1);
        chk("short_err_pulse", err_cnt, 1);
        send_line(8'h50, 0, 4, 1'b0);
        chk("short_count", pq.size(), 7);
        chk("short_p2", pq[2], {px(8'h40, 2), 2'b00});
        chk("short_row1_col0", pq[3], {px(8'h50, 0), 2'b00});
        chk("short_row1_col3_eop", pq[6], {px(8'h50, 3), 2'b01});
        chk("short_single_err", err_cnt, 1);

        // Truncated frame: boundary after 5 pixels, href still high
        vs_pulse();
        pq.delete();
        eb = err_cnt;
        send_line(8'h60, 0, 4, 1'b0);
        send_byte(8'h64);
        send_byte(8'hC4);
        vs_pulse();
        chk("trunc_err", err_cnt, eb + 1);
        chk("trunc_count", pq.size(), 5);
        ne = 0;
        for (int i = 0; i < pq.size(); i++) ne += int'(pq[i][0]);
        chk("trunc_no_eop", ne, 0);
        pq.delete();
        send_frame(8'h70);
        chk_full("after_trunc", 8'h70);

        // Enable low in DONE -> IDLE, no more pixels
        en_capture = 1'b0;
        eb = err_cnt;
        vs_pulse();
        pq.delete();
        send_frame(8'h80);
        vs_pulse();
        send_frame(8'h80);
        chk("idle_no_pixels", pq.size(), 0);
        chk("idle_no_err", err_cnt, eb);

        // Async reset mid-line
        en_capture = 1'b1;
        cyc();
        vs_pulse();
        vs_pulse();
        send_byte(8'h81);
        send_byte(8'hC1);
        chk("prerst_vld_sop", {bus_if.dout_vld, bus_if.dout_sop}, 2'b11);
        rst_n = 1'b0;
        bus_if.href = 1'b0;
        #1;
        chk("rst_async_vld", bus_if.dout_vld, 0);
        chk("rst_async_dout", bus_if.dout, 0);
        chk("rst_async_sop", bus_if.dout_sop, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        pq.delete();
        vs_pulse();
        send_frame(8'h90);
        chk("post_rst_skip", pq.size(), 0);
        vs_pulse();
        send_frame(8'hA0);
        chk_full("post_rst", 8'hA0);
        chk("post_rst_no_err", err_cnt, eb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
